i2s_capture_ctrl: RTL and testbench



---
 rtl/i2s_capture_ctrl.sv | 161 ++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_ctrl.sv
// I2S capture sequencer: receiver gating, mic warm-up discard, mono mix, FIFO.
// Optional CAPTURE_DROP_COUNT_EN builds the saturating dropped-sample counter.

module i2s_capture_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned WARMUP_SAMPLES = 4096
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic [1:0]  channel_sel_in,
    input  logic [15:0] left_sample_in,
    input  logic [15:0] right_sample_in,
    input  logic        new_sample_in,
    output logic        rx_enable_out,
    output logic [15:0] sample_out,
    output logic        sample_valid_out,
    input  logic        sample_ready_in,
    output logic        busy_out,
    output logic        overflow_out,
    output logic [7:0]  drop_count_out
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [15:0] WARM_N  = WARMUP_SAMPLES[15:0];

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        DRAIN
    } state_t;

    state_t      state, state_nx;
    logic [15:0] warm_cnt, warm_cnt_nx;
    logic        capture;
    logic        clear_stats;

    logic        stage_vld;
    logic [15:0] stage_data;
    logic [16:0] sum;
    logic [15:0] sel_sample;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic          push_ok, push_drop, pop;

    always_comb begin
        sum = {left_sample_in[15], left_sample_in}
            + {right_sample_in[15], right_sample_in};
        case (channel_sel_in)
            2'b01:   sel_sample = right_sample_in;
            2'b10:   sel_sample = sum[16:1];
            default: sel_sample = left_sample_in;
        endcase
    end

    // Space is judged on current occupancy only; a same-cycle pop frees nothing.
    assign pop       = (count != '0) && sample_ready_in;
    assign push_ok   = stage_vld && (count < DEPTH_C);
    assign push_drop = stage_vld && !(count < DEPTH_C);
    assign count_nx  = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

    always_comb begin
        state_nx    = state;
        warm_cnt_nx = warm_cnt;
        capture     = 1'b0;
        clear_stats = 1'b0;
        case (state)
            IDLE: begin
                if (start_in && !stop_in) begin
                    state_nx    = WARMUP;
                    warm_cnt_nx = '0;
                    clear_stats = 1'b1;
                end
            end
            WARMUP: begin
                if (stop_in) begin
                    state_nx = IDLE;
                end else if (warm_cnt == WARM_N) begin
                    state_nx = RUN;
                end else if (new_sample_in) begin
                    warm_cnt_nx = warm_cnt + 16'd1;
                    if (warm_cnt_nx == WARM_N) state_nx = RUN;
                end
            end
            RUN: begin
                if (stop_in) state_nx = DRAIN;
                else capture = new_sample_in;
            end
            DRAIN: begin
                if (count_nx == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= IDLE;
            warm_cnt   <= '0;
            stage_vld  <= 1'b0;
            stage_data <= '0;
        end else begin
            state     <= state_nx;
            warm_cnt  <= warm_cnt_nx;
            stage_vld <= capture;
            if (capture) stage_data <= sel_sample;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
        end
    end

    always_ff @(posedge clock_in) begin
        if (push_ok) mem[wr_ptr] <= stage_data;
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in)     overflow_out <= 1'b0;
        else if (clear_stats) overflow_out <= 1'b0;
        else if (push_drop)   overflow_out <= 1'b1;
    end

`ifdef CAPTURE_DROP_COUNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            drop_cnt <= '0;
        end else if (clear_stats) begin
            drop_cnt <= '0;
        end else if (push_drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_count_out = drop_cnt;
`else
    assign drop_count_out = '0;
`endif

    // Output gated by occupancy so reset clears it without waiting for a clock.
    assign sample_valid_out = (count != '0);
    assign sample_out       = sample_valid_out ? mem[rd_ptr] : '0;
    assign rx_enable_out    = (state == WARMUP) || (state == RUN);
    assign busy_out         = (state != IDLE);

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: queue-based reference model plus sample scoreboard.
// Depth 4 and three warm-up samples keep the overflow and warm-up cases short.

module tb_i2s_capture_ctrl;

    localparam int DEPTH = 4;
    localparam int WARM  = 3;
`ifdef CAPTURE_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] l = '0;
    logic [15:0] r = '0;
    logic        ns = 1'b0;
    logic        rdy = 1'b0;
    logic        rx_en;
    logic [15:0] sample;
    logic        valid;
    logic        busy;
    logic        ovf_o;
    logic [7:0]  drop_o;

    always #5 clk = ~clk;

    i2s_capture_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .WARMUP_SAMPLES(WARM)
    ) dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .start_in        (start),
        .stop_in         (stop),
        .channel_sel_in  (sel),
        .left_sample_in  (l),
        .right_sample_in (r),
        .new_sample_in   (ns),
        .rx_enable_out   (rx_en),
        .sample_out      (sample),
        .sample_valid_out(valid),
        .sample_ready_in (rdy),
        .busy_out        (busy),
        .overflow_out    (ovf_o),
        .drop_count_out  (drop_o)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Model: 0 idle, 1 warm-up, 2 run, 3 drain.
    logic [15:0] exp_q[$];
    int          phase = 0;
    int          occ = 0;
    int          wcnt = 0;
    int          drops = 0;
    bit          ovf = 1'b0;
    bit          pend = 1'b0;
    logic [15:0] pend_val = '0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] pick(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [1:0] s);
        int m;
        case (s)
            2'd1: return b;
            2'd2: begin
                m = (int'($signed(a)) + int'($signed(b))) >>> 1;
                return m[15:0];
            end
            default: return a;
        endcase
    endfunction

    always @(negedge clk) begin
        bit pop;
        if (!rst_n) begin
            phase = 0;
            occ   = 0;
            wcnt  = 0;
            drops = 0;
            ovf   = 1'b0;
            pend  = 1'b0;
            exp_q.delete();
        end
        check("rx_enable", rx_en, (phase == 1 || phase == 2));
        check("busy", busy, (phase != 0));
        check("valid", valid, (occ > 0));
        check("overflow", ovf_o, ovf);
        check("drop_count", drop_o, DC_EN ? drops : 0);
        if (rst_n) begin
            pop = rdy && (occ > 0);
            if (pend) begin
                if (occ < DEPTH) begin
                    exp_q.push_back(pend_val);
                    occ++;
                end else begin
                    ovf = 1'b1;
                    if (drops < 255) drops++;
                end
            end
            pend = 1'b0;
            if (pop) occ--;
            case (phase)
                0: if (start && !stop) begin
                    phase = 1;
                    wcnt  = 0;
                    ovf   = 1'b0;
                    drops = 0;
                end
                1: if (stop) phase = 0;
                   else if (wcnt == WARM) phase = 2;
                   else if (ns) begin
                       wcnt++;
                       if (wcnt == WARM) phase = 2;
                   end
                2: if (stop) phase = 3;
                   else if (ns) begin
                       pend     = 1'b1;
                       pend_val = pick(l, r, sel);
                   end
                default: if (occ == 0) phase = 0;
            endcase
        end
    end

    // Monitor: head must match the scoreboard whenever valid; pop on accept.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sample_out: got %0h, expected no sample at %0t",
                         sample, $time);
            end else begin
                check("sample_out", sample, exp_q[0]);
                if (rdy) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] s);
        l  = a;
        r  = b;
        sel = s;
        ns = 1'b1;
        cyc();
        ns = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 100 && occ > 0; i++) cyc();
        cyc(2);
        check(name, valid, 0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && phase != 0; i++) cyc();
        cyc();
        check(name, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_enable"}, rx_en, 0);
        check({tag, "_sample"}, sample, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, ovf_o, 0);
        check({tag, "_drop"}, drop_o, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Warm-up discards three pulses; 0x0400 and 0x0500 emerge.
        do_start();
        cyc();
        for (int i = 1; i <= 5; i++) begin
            pulse(16'(i * 256), 16'h1234, 2'b00);
            cyc(2);
        end
        cyc(2);
        rdy = 1'b1;
        wait_empty("warmup_drain");

        // Channel modes, including average extremes.
        pulse(16'h7FFF, 16'h7FFF, 2'b10); cyc();
        pulse(16'h8000, 16'h7FFF, 2'b10); cyc();
        pulse(16'h0003, 16'h0000, 2'b10); cyc();
        pulse(16'h8000, 16'h8000, 2'b10); cyc();
        pulse(16'h1111, 16'h2222, 2'b01); cyc();
        pulse(16'h3333, 16'h4444, 2'b11); cyc();
        pulse(16'h5555, 16'h6666, 2'b00);
        cyc(3);

        // Back-to-back pulses into a stalled FIFO: four kept, three dropped.
        rdy = 1'b0;
        repeat (7) pulse(16'($urandom), 16'($urandom), 2'($urandom));
        cyc(3);
        check("ovf_sticky", ovf_o, 1);
        check("drop_after_7", drop_o, DC_EN ? 3 : 0);
        rdy = 1'b1;
        wait_empty("overflow_drain");

        // Random traffic in RUN.
        repeat (400) begin
            ns  = ($urandom_range(0, 2) == 0);
            l   = 16'($urandom);
            r   = 16'($urandom);
            sel = 2'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        ns  = 1'b0;
        rdy = 1'b1;
        wait_empty("random_drain");

        // Stop with a same-cycle pulse, start ignored while draining.
        rdy = 1'b0;
        repeat (3) begin
            pulse(16'($urandom), 16'($urandom), 2'($urandom));
            cyc();
        end
        cyc(2);
        l    = 16'hDEAD;
        ns   = 1'b1;
        stop = 1'b1;
        cyc();
        ns   = 1'b0;
        stop = 1'b0;
        check("stop_rx_off", rx_en, 0);
        check("stop_busy", busy, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(2);
        rdy = 1'b1;
        wait_idle("drain_idle");

        // Start and stop together in IDLE; stop during warm-up.
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", busy, 0);
        do_start();
        pulse(16'h0101, 16'h0202, 2'b00);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_in_warmup", busy, 0);
        cyc(2);

        // Asynchronous reset mid-RUN with two samples buffered.
        do_start();
        repeat (WARM) begin
            pulse(16'($urandom), 16'($urandom), 2'b00);
            cyc();
        end
        rdy = 1'b0;
        repeat (2) begin
            pulse(16'($urandom), 16'($urandom), 2'($urandom));
            cyc();
        end
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        do_start();
        check("restart_busy", busy, 1);
        check("restart_overflow", ovf_o, 0);
        repeat (WARM) begin
            pulse(16'($urandom), 16'($urandom), 2'b01);
            cyc();
        end
        rdy = 1'b1;
        repeat (2) begin
            pulse(16'($urandom), 16'($urandom), 2'($urandom));
            cyc();
        end
        cyc(3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_idle("final_idle");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
